// File: rtl/filter_feed_controller_if.sv
// Bundle between filter_feed_controller, the home/neighbour cell memories and filter_dispatcher.
// master: controller side; slave: cell controller / memories / dispatcher side.
interface filter_feed_controller_if #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned PAIR_CNT_WIDTH = 16
);
    logic                      i_start;
    logic [ADDR_WIDTH:0]       i_home_count;
    logic [ADDR_WIDTH:0]       i_nb_count;
    logic                      o_home_rd_en;
    logic [ADDR_WIDTH-1:0]     o_home_rd_addr;
    logic                      o_nb_rd_en;
    logic [ADDR_WIDTH-1:0]     o_nb_rd_addr;
    logic                      o_home_data_valid;
    logic                      o_nb_data_valid;
    logic                      i_dispatcher_back_pressure;
    logic                      i_dispatcher_buffer_empty;
    logic                      o_busy;
    logic                      o_done;
    logic [PAIR_CNT_WIDTH-1:0] o_pair_count;

    modport master (
        input  i_start, i_home_count, i_nb_count,
        input  i_dispatcher_back_pressure, i_dispatcher_buffer_empty,
        output o_home_rd_en, o_home_rd_addr, o_nb_rd_en, o_nb_rd_addr,
        output o_home_data_valid, o_nb_data_valid, o_busy, o_done, o_pair_count
    );

    modport slave (
        output i_start, i_home_count, i_nb_count,
        output i_dispatcher_back_pressure, i_dispatcher_buffer_empty,
        input  o_home_rd_en, o_home_rd_addr, o_nb_rd_en, o_nb_rd_addr,
        input  o_home_data_valid, o_nb_data_valid, o_busy, o_done, o_pair_count
    );
endinterface

// File: rtl/filter_feed_controller.sv
// Sequences one home-cell vs neighbour-cell pass into filter_dispatcher: one home read per
// home particle, then every neighbour particle streamed under dispatcher back-pressure.
module filter_feed_controller #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned PAIR_CNT_WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    filter_feed_controller_if.master bus
);
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, HOME_RD, HOME_WAIT, NB_STREAM, NEXT_HOME, DRAIN, DONE
    } state_t;

    state_t                    state, state_d;
    logic [CNT_WIDTH-1:0]      home_cnt, home_cnt_d, nb_cnt, nb_cnt_d;
    logic [CNT_WIDTH-1:0]      home_idx, home_idx_d, nb_idx, nb_idx_d;
    logic [CNT_WIDTH-1:0]      home_idx_inc, nb_last;
    logic                      home_rd_en, home_rd_en_d, nb_rd_en, nb_rd_en_d;
    logic [ADDR_WIDTH-1:0]     home_rd_addr, home_rd_addr_d, nb_rd_addr, nb_rd_addr_d;
    logic                      busy, busy_d, done, done_d;
    logic [PAIR_CNT_WIDTH-1:0] pair_cnt, pair_cnt_d;
    logic                      home_valid, nb_valid;

    assign home_idx_inc = home_idx + CNT_WIDTH'(1);
    assign nb_last      = nb_cnt - CNT_WIDTH'(1);

    // Outputs are registered, so each branch computes what is presented in the next cycle.
    // HOME_WAIT already makes the first neighbour decision, giving a 2-cycle home->nb valid lead.
    always_comb begin
        state_d        = state;
        home_cnt_d     = home_cnt;
        nb_cnt_d       = nb_cnt;
        home_idx_d     = home_idx;
        nb_idx_d       = nb_idx;
        home_rd_en_d   = 1'b0;
        home_rd_addr_d = home_rd_addr;
        nb_rd_en_d     = 1'b0;
        nb_rd_addr_d   = nb_rd_addr;
        busy_d         = busy;
        done_d         = 1'b0;
        pair_cnt_d     = pair_cnt;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    home_cnt_d = bus.i_home_count;
                    nb_cnt_d   = bus.i_nb_count;
                    home_idx_d = '0;
                    nb_idx_d   = '0;
                    pair_cnt_d = '0;
                    busy_d     = 1'b1;
                    if (bus.i_home_count == '0 || bus.i_nb_count == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d        = HOME_RD;
                        home_rd_en_d   = 1'b1;
                        home_rd_addr_d = '0;
                    end
                end
            end
            HOME_RD: state_d = HOME_WAIT;
            HOME_WAIT, NB_STREAM: begin
                state_d = NB_STREAM;
                if (!bus.i_dispatcher_back_pressure) begin
                    nb_rd_en_d   = 1'b1;
                    nb_rd_addr_d = nb_idx[ADDR_WIDTH-1:0];
                    nb_idx_d     = nb_idx + CNT_WIDTH'(1);
                    if (pair_cnt != '1) begin
                        pair_cnt_d = pair_cnt + PAIR_CNT_WIDTH'(1);
                    end
                    if (nb_idx == nb_last) begin
                        state_d = NEXT_HOME;
                    end
                end
            end
            NEXT_HOME: begin
                home_idx_d = home_idx_inc;
                nb_idx_d   = '0;
                if (home_idx_inc == home_cnt) begin
                    state_d = DRAIN;
                end else begin
                    state_d        = HOME_RD;
                    home_rd_en_d   = 1'b1;
                    home_rd_addr_d = home_idx_inc[ADDR_WIDTH-1:0];
                end
            end
            DRAIN: begin
                if (bus.i_dispatcher_buffer_empty && !nb_valid && !nb_rd_en) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            home_cnt     <= '0;
            nb_cnt       <= '0;
            home_idx     <= '0;
            nb_idx       <= '0;
            home_rd_en   <= 1'b0;
            home_rd_addr <= '0;
            nb_rd_en     <= 1'b0;
            nb_rd_addr   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pair_cnt     <= '0;
            home_valid   <= 1'b0;
            nb_valid     <= 1'b0;
        end else begin
            state        <= state_d;
            home_cnt     <= home_cnt_d;
            nb_cnt       <= nb_cnt_d;
            home_idx     <= home_idx_d;
            nb_idx       <= nb_idx_d;
            home_rd_en   <= home_rd_en_d;
            home_rd_addr <= home_rd_addr_d;
            nb_rd_en     <= nb_rd_en_d;
            nb_rd_addr   <= nb_rd_addr_d;
            busy         <= busy_d;
            done         <= done_d;
            pair_cnt     <= pair_cnt_d;
            home_valid   <= home_rd_en;
            nb_valid     <= nb_rd_en;
        end
    end

    assign bus.o_home_rd_en      = home_rd_en;
    assign bus.o_home_rd_addr    = home_rd_addr;
    assign bus.o_nb_rd_en        = nb_rd_en;
    assign bus.o_nb_rd_addr      = nb_rd_addr;
    assign bus.o_home_data_valid = home_valid;
    assign bus.o_nb_data_valid   = nb_valid;
    assign bus.o_busy            = busy;
    assign bus.o_done            = done;
    assign bus.o_pair_count      = pair_cnt;
endmodule

// File: tb/tb_filter_feed_controller.sv
// Self-checking bench for filter_feed_controller: directed and random passes compared against
// per-pass expectations derived from home/neighbour counts.
module tb_filter_feed_controller;
    localparam int unsigned ADDR_WIDTH     = 8;
    localparam int unsigned PAIR_CNT_WIDTH = 16;
    localparam int unsigned CNT_W          = ADDR_WIDTH + 1;
    localparam int          PAIR_MAX       = (1 << PAIR_CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst;

    filter_feed_controller_if #(.ADDR_WIDTH(ADDR_WIDTH), .PAIR_CNT_WIDTH(PAIR_CNT_WIDTH)) bus ();

    filter_feed_controller #(.ADDR_WIDTH(ADDR_WIDTH), .PAIR_CNT_WIDTH(PAIR_CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-pass event log, filled by the monitor and cleared whenever epoch changes.
    int epoch = 0;
    int seen_epoch = 0;
    int mcyc = 0;
    int home_rd_addr_q[$], home_rd_cyc_q[$], nb_rd_addr_q[$], nb_rd_cyc_q[$];
    int home_val_cyc_q[$], nb_val_cyc_q[$];
    int done_n = 0;
    int dly_err = 0;
    int bp_err = 0;
    logic prev_home_rd = 1'b0, prev_nb_rd = 1'b0, prev_bp = 1'b0, prev_rst = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (epoch != seen_epoch) begin
                home_rd_addr_q.delete(); home_rd_cyc_q.delete();
                nb_rd_addr_q.delete();   nb_rd_cyc_q.delete();
                home_val_cyc_q.delete(); nb_val_cyc_q.delete();
                done_n = 0; dly_err = 0; bp_err = 0;
                seen_epoch = epoch;
            end
            mcyc++;
            if (!rst && !prev_rst) begin
                if (bus.o_home_data_valid !== prev_home_rd) dly_err++;
                if (bus.o_nb_data_valid !== prev_nb_rd) dly_err++;
            end
            if (!rst) begin
                if (bus.o_home_rd_en) begin
                    home_rd_addr_q.push_back(int'(bus.o_home_rd_addr));
                    home_rd_cyc_q.push_back(mcyc);
                end
                if (bus.o_nb_rd_en) begin
                    nb_rd_addr_q.push_back(int'(bus.o_nb_rd_addr));
                    nb_rd_cyc_q.push_back(mcyc);
                end
                if (bus.o_home_data_valid) home_val_cyc_q.push_back(mcyc);
                if (bus.o_nb_data_valid) nb_val_cyc_q.push_back(mcyc);
                if (bus.o_done) done_n++;
                // Two cycles of back-pressure must have stopped new neighbour reads.
                if (bus.o_nb_rd_en && prev_bp && bus.i_dispatcher_back_pressure) bp_err++;
            end
            prev_home_rd = bus.o_home_rd_en;
            prev_nb_rd   = bus.o_nb_rd_en;
            prev_bp      = bus.i_dispatcher_back_pressure;
            prev_rst     = rst;
        end
    end

    task automatic chk(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " home_rd_en"}, int'(bus.o_home_rd_en), 0);
        chk({tag, " home_rd_addr"}, int'(bus.o_home_rd_addr), 0);
        chk({tag, " nb_rd_en"}, int'(bus.o_nb_rd_en), 0);
        chk({tag, " nb_rd_addr"}, int'(bus.o_nb_rd_addr), 0);
        chk({tag, " home_valid"}, int'(bus.o_home_data_valid), 0);
        chk({tag, " nb_valid"}, int'(bus.o_nb_data_valid), 0);
        chk({tag, " busy"}, int'(bus.o_busy), 0);
        chk({tag, " done"}, int'(bus.o_done), 0);
        chk({tag, " pair_count"}, int'(bus.o_pair_count), 0);
    endtask

    // mode 0: no back-pressure; 1: random back-pressure; 2: 3-cycle back-pressure after 2nd nb read;
    // 3: buffer_empty low until 20 cycles after last nb read; 4: extra start pulse while busy;
    // 5: buffer_empty low until 5 cycles after start.
    task automatic run_pass(input int h, input int n, input int mode, output int done_t, output int mark_t);
        int issued = 0;
        int hold = 0;
        int t = 0;
        int last_t = -1;
        int total = h * n;
        int limit = 200 + h * (n + 4) * 4;
        done_t = -1;
        mark_t = -1;
        epoch++;
        @(posedge clk); #1;
        bus.i_home_count = CNT_W'(h);
        bus.i_nb_count   = CNT_W'(n);
        bus.i_start      = 1'b1;
        bus.i_dispatcher_back_pressure = 1'b0;
        bus.i_dispatcher_buffer_empty  = !(mode == 3 || mode == 5);
        while (done_t < 0 && t < limit) begin
            @(posedge clk); #1;
            t++;
            bus.i_start = (mode == 4 && t == 4);
            if (bus.o_done) done_t = t;
            if (bus.o_nb_rd_en) issued++;
            case (mode)
                1: bus.i_dispatcher_back_pressure = ($urandom_range(0, 3) == 0);
                2: begin
                    if (bus.o_nb_rd_en && issued == 2) hold = 3;
                    bus.i_dispatcher_back_pressure = (hold > 0);
                    if (hold > 0) hold--;
                end
                3: begin
                    if (bus.o_nb_rd_en && issued == total) last_t = t;
                    if (last_t >= 0 && t == last_t + 20) begin
                        bus.i_dispatcher_buffer_empty = 1'b1;
                        mark_t = t;
                    end
                end
                5: if (t == 5) begin
                    bus.i_dispatcher_buffer_empty = 1'b1;
                    mark_t = t;
                end
                default: bus.i_dispatcher_back_pressure = 1'b0;
            endcase
        end
        chk($sformatf("done_seen h=%0d n=%0d", h, n), int'(done_t >= 0), 1);
        bus.i_start = 1'b0;
        bus.i_dispatcher_back_pressure = 1'b0;
        bus.i_dispatcher_buffer_empty  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string name, input int h, input int n, input bit check_lead);
        int hr = (n == 0) ? 0 : h;
        int tot = h * n;
        int bad;
        chk({name, " home_rd_n"}, home_rd_addr_q.size(), hr);
        bad = 0;
        foreach (home_rd_addr_q[i]) if (home_rd_addr_q[i] != i) bad++;
        chk({name, " home_addr_seq"}, bad, 0);
        chk({name, " nb_rd_n"}, nb_rd_addr_q.size(), tot);
        bad = 0;
        foreach (nb_rd_addr_q[i]) if (n == 0 || nb_rd_addr_q[i] != i % n) bad++;
        chk({name, " nb_addr_seq"}, bad, 0);
        chk({name, " home_valid_n"}, home_val_cyc_q.size(), hr);
        chk({name, " nb_valid_n"}, nb_val_cyc_q.size(), tot);
        bad = 0;
        for (int g = 1; g < hr; g++) begin
            if (g < home_rd_cyc_q.size() && g * n - 1 < nb_rd_cyc_q.size()) begin
                if (home_rd_cyc_q[g] <= nb_rd_cyc_q[g * n - 1]) bad++;
            end
        end
        chk({name, " home_after_prev_nbs"}, bad, 0);
        if (check_lead) begin
            bad = 0;
            for (int g = 0; g < hr; g++) begin
                if (g < home_val_cyc_q.size() && g * n < nb_val_cyc_q.size()) begin
                    if (nb_val_cyc_q[g * n] - home_val_cyc_q[g] != 2) bad++;
                end else begin
                    bad++;
                end
            end
            chk({name, " home_lead_2"}, bad, 0);
        end
        chk({name, " pair_count"}, int'(bus.o_pair_count), (tot > PAIR_MAX) ? PAIR_MAX : tot);
        chk({name, " done_pulses"}, done_n, 1);
        chk({name, " busy_after"}, int'(bus.o_busy), 0);
        chk({name, " valid_delay"}, dly_err, 0);
        chk({name, " bp_respected"}, bp_err, 0);
    endtask

    initial begin
        int done_t, mark_t, h, n, issued, t;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_home_count = '0;
        bus.i_nb_count = '0;
        bus.i_dispatcher_back_pressure = 1'b0;
        bus.i_dispatcher_buffer_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_pass(2, 3, 0, done_t, mark_t);
        verify("h2n3", 2, 3, 1'b1);

        run_pass(1, 5, 2, done_t, mark_t);
        verify("h1n5_bp", 1, 5, 1'b1);
        if (nb_rd_cyc_q.size() >= 3) chk("bp_stall_gap", nb_rd_cyc_q[2] - nb_rd_cyc_q[1], 4);
        else chk("bp_stall_reads", nb_rd_cyc_q.size(), 5);

        run_pass(0, 4, 5, done_t, mark_t);
        verify("h0n4", 0, 4, 1'b0);
        chk("h0n4 done_after_empty", done_t, mark_t + 1);
        run_pass(3, 0, 5, done_t, mark_t);
        verify("h3n0", 3, 0, 1'b0);
        chk("h3n0 done_after_empty", done_t, mark_t + 1);

        run_pass(1, 2, 3, done_t, mark_t);
        verify("h1n2_drain", 1, 2, 1'b1);
        chk("h1n2 done_after_empty", done_t, mark_t + 1);

        // Asynchronous reset after the 5th neighbour read of a 3x4 pass.
        epoch++;
        @(posedge clk); #1;
        bus.i_home_count = CNT_W'(3);
        bus.i_nb_count   = CNT_W'(4);
        bus.i_start      = 1'b1;
        issued = 0;
        t = 0;
        while (issued < 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
            bus.i_start = 1'b0;
            if (bus.o_nb_rd_en) issued++;
        end
        chk("rst_mid reached 5 reads", issued, 5);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid no_done", done_n, 0);
        chk("rst_mid busy_low", int'(bus.o_busy), 0);
        run_pass(1, 1, 0, done_t, mark_t);
        verify("after_rst_h1n1", 1, 1, 1'b1);

        run_pass(2, 2, 4, done_t, mark_t);
        verify("start_while_busy", 2, 2, 1'b1);

        for (int k = 0; k < 6; k++) begin
            h = $urandom_range(1, 4);
            n = $urandom_range(1, 6);
            run_pass(h, n, 1, done_t, mark_t);
            verify($sformatf("rand%0d_h%0dn%0d", k, h, n), h, n, 1'b0);
        end

        run_pass(1, 256, 0, done_t, mark_t);
        verify("h1n256", 1, 256, 1'b1);
        run_pass(256, 1, 1, done_t, mark_t);
        verify("h256n1", 256, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/filter_feed_controller.md
Name: filter_feed_controller

Overview:
- Sequences one home-cell vs. neighbour-cell evaluation pass into filter_dispatcher.
- For each home particle, reads its offset packet once from home-cell memory, then streams every neighbour particle from neighbour-cell memory.
- Throttles on dispatcher back-pressure and reports done once the dispatcher buffer has drained.
- Sits between the cell memories / cell controller and filter_dispatcher.

Parameters:
- ADDR_WIDTH, 8, address width of both cell memories (max 2^ADDR_WIDTH particles per cell).
- PAIR_CNT_WIDTH, 16, width of the issued-pair counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; starts a pass (ignored unless IDLE)
- i_home_count  in  ADDR_WIDTH+1  number of home particles, sampled on accepted start
- i_nb_count  in  ADDR_WIDTH+1  number of neighbour particles, sampled on accepted start
- o_home_rd_en  out  1  home memory read enable
- o_home_rd_addr  out  ADDR_WIDTH  home memory read address
- o_nb_rd_en  out  1  neighbour memory read enable
- o_nb_rd_addr  out  ADDR_WIDTH  neighbour memory read address
- o_home_data_valid  out  1  to dispatcher i_home_data_valid
- o_nb_data_valid  out  1  to dispatcher i_nb_data_valid
- i_dispatcher_back_pressure  in  1  dispatcher almost-full
- i_dispatcher_buffer_empty  in  1  dispatcher idle/empty
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse at end of pass
- o_pair_count  out  PAIR_CNT_WIDTH  neighbour reads issued this pass; saturates at all-ones

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - Internal home/nb indices and sampled counts 0.
- Memory read latency is fixed at 1 cycle.
  - o_home_data_valid is o_home_rd_en delayed one cycle.
  - o_nb_data_valid is o_nb_rd_en delayed one cycle.
  - Both are cleared by rst.
- Dispatcher asserts back-pressure with at least 2 entries of headroom.
  - The controller only stops issuing new reads.
  - An in-flight read always completes and is presented.
- State machine:
  - IDLE:
    - On i_start, latch counts, clear o_pair_count and indices, set o_busy.
    - If either count is 0, go to DRAIN (no reads issued).
    - Otherwise go to HOME_RD.
  - HOME_RD:
    - Assert o_home_rd_en for exactly one cycle at addr = home index.
    - Go to HOME_WAIT.
  - HOME_WAIT:
    - One cycle, so that o_home_data_valid precedes the first neighbour valid.
    - Go to NB_STREAM with nb index 0.
  - NB_STREAM:
    - Each cycle with back_pressure low: o_nb_rd_en=1, addr=nb index, nb index++, o_pair_count++.
    - With back_pressure high: o_nb_rd_en=0 and index holds.
    - After issuing index i_nb_count-1, go to NEXT_HOME.
  - NEXT_HOME:
    - home index++.
    - If it equals i_home_count, go to DRAIN; else go to HOME_RD.
    - Home index is not re-read before the last neighbour of the previous home has been issued.
  - DRAIN:
    - Wait until i_dispatcher_buffer_empty=1 and no nb valid is in flight (delay register clear).
    - Then go to DONE.
  - DONE:
    - o_done=1 for one cycle, o_busy falls in the same cycle.
    - Go to IDLE.
- Start while busy is ignored. Start and rst in the same cycle: rst wins.
- Counts equal to 2^ADDR_WIDTH are legal. Addresses wrap from all-ones to 0 only by termination, never by overflow.
- o_pair_count stops at all-ones (no wrap).
- Async reset mid-pass returns to IDLE immediately and kills any in-flight valid. No o_done is produced.

Test Plan:
- home=2, nb=3, no back-pressure:
  - Home reads at addr 0 then 1.
  - 3 neighbour reads (0,1,2) per home.
  - 6 nb valids, o_pair_count=6.
  - Each o_home_data_valid leads the first nb valid of its group by exactly 2 cycles.
  - o_done pulses once after buffer_empty.
- home=1, nb=5, back_pressure high for 3 cycles after the 2nd nb read:
  - Reads stall at addr 2 for 3 cycles, then resume 2,3,4.
  - No duplicate or skipped address; o_pair_count=5.
- home=0 or nb=0:
  - No rd_en ever asserted.
  - o_done 1 cycle after buffer_empty=1; o_pair_count=0.
- home=1, nb=2, buffer_empty held low 20 cycles after the last read:
  - o_done asserted only in the cycle after buffer_empty rises.
- rst asserted mid-NB_STREAM (home=3, nb=4, after 5 reads):
  - All outputs 0 immediately; no o_done.
  - A subsequent start with home=1, nb=1 produces exactly 1 home read, 1 nb read, o_pair_count=1.
- i_start pulsed while o_busy=1 (home=2, nb=2):
  - Ignored; pass completes with o_pair_count=4 and a single o_done.
